// File: rtl/ready_valid_source.sv
// ready_valid_source: FIFO-buffered source side of a single-clock ready/valid bus,
// with an optional idle gap after each transfer. Define RV_SOURCE_STATS_EN for transfer/stall counters.
module ready_valid_source #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int IDLE_GAP   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    output logic                       full,
    output logic [$clog2(DEPTH+2)-1:0] count,
    output logic                       valid,
    output logic [DATA_WIDTH-1:0]      data,
    input  logic                       ready
`ifdef RV_SOURCE_STATS_EN
    ,
    output logic [15:0]                xfer_count,
    output logic [15:0]                stall_count
`endif
);

    localparam int CW = $clog2(DEPTH + 2);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } state_e;

    state_e                state_r;
    state_e                state_s;
    logic [3:0]            gap_cnt_r;
    logic [3:0]            gap_cnt_s;
    logic                  valid_r;
    logic                  valid_s;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] data_in_s;
    logic                  stage_full_r;
    logic                  stage_full_s;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [FW-1:0]         fifo_cnt_r;
    logic [FW-1:0]         fifo_cnt_s;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_s;
    logic                  full_r;
    logic                  full_s;

    logic                  xfer_s;
    logic                  push_ok_s;
    logic                  stage_free_s;
    logic                  fifo_empty_s;
    logic                  pop_s;
    logic                  bypass_s;
    logic                  fifo_wr_s;
    logic                  stage_load_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Handshake and buffer steering. The output stage refills as soon as it is freed,
    // even during a gap, so an empty stage always implies an empty FIFO.
    always_comb begin
        xfer_s       = valid_r & ready;
        push_ok_s    = push & ~full_r;
        stage_free_s = ~stage_full_r | xfer_s;
        fifo_empty_s = (fifo_cnt_r == {FW{1'b0}});
        pop_s        = stage_free_s & ~fifo_empty_s;
        bypass_s     = stage_free_s & fifo_empty_s & push_ok_s;
        fifo_wr_s    = push_ok_s & ~bypass_s;
        stage_load_s = pop_s | bypass_s;
        stage_full_s = stage_load_s | ~stage_free_s;
        if (pop_s) begin
            data_in_s = mem_r[rd_ptr_r];
        end else begin
            data_in_s = push_data;
        end
        fifo_cnt_s = fifo_cnt_r + {{(FW-1){1'b0}}, fifo_wr_s} - {{(FW-1){1'b0}}, pop_s};
        count_s    = count_r + {{(CW-1){1'b0}}, push_ok_s} - {{(CW-1){1'b0}}, xfer_s};
        full_s     = (count_s == CW'(DEPTH + 1));
    end

    // Next-state logic for the bus presentation FSM.
    always_comb begin
        state_s   = state_r;
        gap_cnt_s = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (stage_full_s) begin
                    state_s = ST_PRESENT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (!xfer_s) begin
                    state_s = ST_PRESENT;
                end else if (IDLE_GAP > 0) begin
                    state_s   = ST_GAP;
                    gap_cnt_s = 4'(IDLE_GAP - 1);
                end else if (stage_full_s) begin
                    state_s = ST_PRESENT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r != 4'd0) begin
                    gap_cnt_s = gap_cnt_r - 4'd1;
                end else if (stage_full_s) begin
                    state_s = ST_PRESENT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                gap_cnt_s = 4'd0;
            end
        endcase
    end

    // Output decode: valid is asserted exactly while presenting.
    always_comb begin
        valid_s = 1'b0;
        if (state_s == ST_PRESENT) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
    end

    // State, output and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            gap_cnt_r    <= 4'd0;
            valid_r      <= 1'b0;
            data_r       <= {DATA_WIDTH{1'b0}};
            stage_full_r <= 1'b0;
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            fifo_cnt_r   <= {FW{1'b0}};
            count_r      <= {CW{1'b0}};
            full_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            gap_cnt_r    <= gap_cnt_s;
            valid_r      <= valid_s;
            stage_full_r <= stage_full_s;
            fifo_cnt_r   <= fifo_cnt_s;
            count_r      <= count_s;
            full_r       <= full_s;
            if (stage_load_s) begin
                data_r <= data_in_s;
            end
            if (fifo_wr_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
        end
    end

    // FIFO storage; contents are qualified by the count so it needs no reset.
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign count = count_r;
    assign full  = full_r;

`ifdef RV_SOURCE_STATS_EN
    logic [15:0] xfer_count_r;
    logic [15:0] stall_count_r;

    // Free-running transfer and stall counters, wrapping at 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_r  <= 16'd0;
            stall_count_r <= 16'd0;
        end else begin
            if (xfer_s) begin
                xfer_count_r <= xfer_count_r + 16'd1;
            end
            if (valid_r && !ready) begin
                stall_count_r <= stall_count_r + 16'd1;
            end
        end
    end

    assign xfer_count  = xfer_count_r;
    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_ready_valid_source.sv
// Testbench for ready_valid_source: directed vector table, hand-written multi-cycle
// sequences and randomized traffic against a queue-based reference model.
module tb_ready_valid_source;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push_a = 1'b0, rdy_a = 1'b0, full_a, valid_a;
    logic [7:0] pd_a = 8'd0, data_a;
    logic [2:0] cnt_a;
    logic       push_b = 1'b0, rdy_b = 1'b0, full_b, valid_b;
    logic [7:0] pd_b = 8'd0, data_b;
    logic [2:0] cnt_b;
`ifdef RV_SOURCE_STATS_EN
    logic [15:0] xc_a, sc_a, xc_b, sc_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ready_valid_source #(.DATA_WIDTH(8), .DEPTH(DEPTH), .IDLE_GAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .push(push_a), .push_data(pd_a), .full(full_a),
        .count(cnt_a), .valid(valid_a), .data(data_a), .ready(rdy_a)
`ifdef RV_SOURCE_STATS_EN
        , .xfer_count(xc_a), .stall_count(sc_a)
`endif
    );

    ready_valid_source #(.DATA_WIDTH(8), .DEPTH(DEPTH), .IDLE_GAP(2)) dut_g (
        .clk(clk), .rst_n(rst_n), .push(push_b), .push_data(pd_b), .full(full_b),
        .count(cnt_b), .valid(valid_b), .data(data_b), .ready(rdy_b)
`ifdef RV_SOURCE_STATS_EN
        , .xfer_count(xc_b), .stall_count(sc_b)
`endif
    );

    typedef struct {
        bit         push;
        logic [7:0] pd;
        bit         rdy;
        bit         ev;
        logic [7:0] ed;
        int         ec;
        bit         ef;
    } vec_t;

    vec_t vecs[$];

    // Reference model: words held in order (output stage first), bus valid, gap remaining.
    logic [7:0]  mq[$];
    bit          mvalid;
    int          mgap;
    logic [15:0] mx, ms;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit p, input logic [7:0] d, input bit r,
                       input bit ev, input logic [7:0] ed, input int ec, input bit ef);
        vec_t v;
        v.push = p; v.pd = d; v.rdy = r; v.ev = ev; v.ed = ed; v.ec = ec; v.ef = ef;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        push_a = 1'b0; rdy_a = 1'b0; push_b = 1'b0; rdy_b = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mq.delete(); mvalid = 1'b0; mgap = 0; mx = 16'd0; ms = 16'd0;
    endtask

    task automatic model_edge(input int g, input bit p, input logic [7:0] d, input bit r);
        bit x, acc;
        x   = mvalid && r;
        acc = p && (mq.size() < DEPTH + 1);
        if (mvalid && !r) ms = ms + 16'd1;
        if (x) begin
            mx = mx + 16'd1;
            void'(mq.pop_front());
        end
        if (acc) mq.push_back(d);
        if (x) begin
            if (g > 0) begin
                mvalid = 1'b0;
                mgap   = g - 1;
            end else begin
                mvalid = (mq.size() > 0);
            end
        end else if (!mvalid) begin
            if (mgap > 0) mgap--;
            else mvalid = (mq.size() > 0);
        end
    endtask

    initial begin
        // Directed table on the IDLE_GAP=0 instance.
        add(1, 8'hA5, 1, 1, 8'hA5, 1, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);
        add(1, 8'h01, 0, 1, 8'h01, 1, 0);
        add(1, 8'h02, 0, 1, 8'h01, 2, 0);
        add(1, 8'h03, 0, 1, 8'h01, 3, 0);
        add(0, 8'h00, 0, 1, 8'h01, 3, 0);
        add(0, 8'h00, 1, 1, 8'h02, 2, 0);
        add(0, 8'h00, 1, 1, 8'h03, 1, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);
        add(1, 8'h11, 0, 1, 8'h11, 1, 0);
        add(1, 8'h12, 0, 1, 8'h11, 2, 0);
        add(1, 8'h13, 0, 1, 8'h11, 3, 0);
        add(1, 8'h14, 0, 1, 8'h11, 4, 0);
        add(1, 8'h15, 0, 1, 8'h11, 5, 1);
        add(1, 8'h16, 0, 1, 8'h11, 5, 1);
        add(1, 8'h17, 1, 1, 8'h12, 4, 0);
        add(0, 8'h00, 1, 1, 8'h13, 3, 0);
        add(0, 8'h00, 1, 1, 8'h14, 2, 0);
        add(0, 8'h00, 1, 1, 8'h15, 1, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);
        add(1, 8'h21, 0, 1, 8'h21, 1, 0);
        add(1, 8'h22, 1, 1, 8'h22, 1, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, 0, 0);

        do_reset();
        check("reset_valid", valid_a, 1'b0);
        check("reset_data", data_a, 8'h00);
        check("reset_count", cnt_a, 3'd0);
        check("reset_full", full_a, 1'b0);

        foreach (vecs[i]) begin
            push_a = vecs[i].push; pd_a = vecs[i].pd; rdy_a = vecs[i].rdy;
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), valid_a, vecs[i].ev);
            check($sformatf("vec%0d_count", i), cnt_a, vecs[i].ec);
            check($sformatf("vec%0d_full", i), full_a, vecs[i].ef);
            if (vecs[i].ev) check($sformatf("vec%0d_data", i), data_a, vecs[i].ed);
        end
        push_a = 1'b0; rdy_a = 1'b0;

        // Asynchronous reset while three words are held and stalled.
        for (int i = 0; i < 3; i++) begin
            push_a = 1'b1; pd_a = 8'h41 + 8'(i);
            @(posedge clk); #1;
        end
        push_a = 1'b0;
        check("pre_rst_count", cnt_a, 3'd3);
        check("pre_rst_valid", valid_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", valid_a, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_count", cnt_a, 3'd0);
        check("post_rst_valid", valid_a, 1'b0);

        // IDLE_GAP=2: three queued words then ready held high.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_b = 1'b1; pd_b = 8'h31 + 8'(i);
            @(posedge clk); #1;
        end
        push_b = 1'b0;
        check("gap_pre_count", cnt_b, 3'd3);
        check("gap_pre_data", data_b, 8'h31);
        rdy_b = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            check($sformatf("gap_k%0d_valid", k), valid_b, (k == 2 || k == 5) ? 1'b1 : 1'b0);
            check($sformatf("gap_k%0d_count", k), cnt_b, (k < 6) ? 2 - k / 3 : 0);
            if (k == 2) check("gap_k2_data", data_b, 8'h32);
            if (k == 5) check("gap_k5_data", data_b, 8'h33);
        end
        rdy_b = 1'b0;

`ifdef RV_SOURCE_STATS_EN
        // Four transfers with five stall edges in total.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_a = (i < 4); pd_a = 8'h50 + 8'(i); rdy_a = 1'b0;
            @(posedge clk); #1;
        end
        push_a = 1'b0; rdy_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        rdy_a = 1'b0;
        check("stats_xfer", xc_a, 16'd4);
        check("stats_stall", sc_a, 16'd5);
`endif

        // Randomized traffic against the model, for each gap setting.
        for (int sel = 0; sel < 2; sel++) begin
            do_reset();
            for (int i = 0; i < 2000; i++) begin
                bit p, r;
                logic [7:0] d;
                int mode;
                mode = (i / 200) % 3;
                p = ($urandom_range(0, 1) == 1);
                d = 8'($urandom);
                if (mode == 0)      r = ($urandom_range(0, 3) != 0);
                else if (mode == 1) r = ($urandom_range(0, 5) == 0);
                else                r = ($urandom_range(0, 1) == 1);
                if (sel == 0) begin
                    push_a = p; pd_a = d; rdy_a = r;
                end else begin
                    push_b = p; pd_b = d; rdy_b = r;
                end
                @(posedge clk);
                model_edge(sel == 0 ? 0 : 2, p, d, r);
                #1;
                if (sel == 0) begin
                    check("rnd0_valid", valid_a, mvalid);
                    check("rnd0_count", cnt_a, mq.size());
                    check("rnd0_full", full_a, mq.size() == DEPTH + 1);
                    if (mvalid) check("rnd0_data", data_a, mq[0]);
                end else begin
                    check("rnd2_valid", valid_b, mvalid);
                    check("rnd2_count", cnt_b, mq.size());
                    check("rnd2_full", full_b, mq.size() == DEPTH + 1);
                    if (mvalid) check("rnd2_data", data_b, mq[0]);
                end
            end
`ifdef RV_SOURCE_STATS_EN
            if (sel == 0) begin
                check("rnd0_xfer_count", xc_a, mx);
                check("rnd0_stall_count", sc_a, ms);
            end else begin
                check("rnd2_xfer_count", xc_b, mx);
                check("rnd2_stall_count", sc_b, ms);
            end
`endif
            push_a = 1'b0; rdy_a = 1'b0; push_b = 1'b0; rdy_b = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
